// File: rtl/decoder_group_fifo_pkg.sv
// Shared defaults and helpers for the grouped decoder input FIFO.
// Defines default geometry, the largest supported read group and the level width.
package decoder_group_fifo_pkg;

    localparam int DECODER_FIFO_AW_DEF       = 14;
    localparam int DECODER_FIFO_DW_DEF       = 1;
    localparam int DECODER_FIFO_RD_GROUP_DEF = 2;
    localparam int DECODER_FIFO_RD_GROUP_MAX = 4;

    // Pointers and level carry one extra bit so that full and empty are distinct.
    function automatic int decoder_fifo_level_w(input int aw);
        return aw + 1;
    endfunction

    typedef struct packed {
        logic wr;
        logic rd;
    } fifo_acc_t;

endpackage

// File: rtl/decoder_group_fifo_ram.sv
// Storage for the grouped decoder FIFO: one write port and RD_GROUP registered
// read ports reading consecutive addresses (wrapping modulo 2**AW).
module decoder_group_fifo_ram
    import decoder_group_fifo_pkg::*;
#(
    parameter int AW       = DECODER_FIFO_AW_DEF,
    parameter int DW       = DECODER_FIFO_DW_DEF,
    parameter int RD_GROUP = DECODER_FIFO_RD_GROUP_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [DW-1:0]          wr_data,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [RD_GROUP*DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Slot 0 holds the oldest entry and lands in the most significant slice.
    for (genvar k = 0; k < RD_GROUP; k++) begin : g_rd_port
        logic [AW-1:0] addr;
        logic [DW-1:0] data_d;
        logic [DW-1:0] data_q;

        assign addr = rd_addr + AW'(k);

        always_comb begin
            data_d = data_q;
            if (rd_en) begin
                data_d = mem[addr];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign rd_data[(RD_GROUP-1-k)*DW +: DW] = data_q;
    end

endmodule

// File: rtl/decoder_group_fifo.sv
// Grouped input FIFO for the decoder chain: one entry per write, RD_GROUP entries per read.
// Optional sticky ovf_err/unf_err outputs are enabled by defining DECODER_FIFO_ERR_FLAGS_EN.
module decoder_group_fifo
    import decoder_group_fifo_pkg::*;
#(
    parameter int AW       = DECODER_FIFO_AW_DEF,
    parameter int DW       = DECODER_FIFO_DW_DEF,
    parameter int RD_GROUP = DECODER_FIFO_RD_GROUP_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   we,
    input  logic [DW-1:0]          data_in,
    input  logic                   re,
    output logic [RD_GROUP*DW-1:0] data_out,
    output logic                   valid_out,
    output logic                   wr_ready,
    output logic                   rd_ready,
    output logic [AW:0]            level
`ifdef DECODER_FIFO_ERR_FLAGS_EN
    ,
    output logic                   ovf_err,
    output logic                   unf_err
`endif
);

    localparam int            LW    = decoder_fifo_level_w(AW);
    localparam logic [LW-1:0] ONE   = LW'(1);
    localparam logic [LW-1:0] DEPTH = ONE << AW;
    localparam logic [LW-1:0] GROUP = LW'(RD_GROUP);

    if (RD_GROUP < 1 || RD_GROUP > DECODER_FIFO_RD_GROUP_MAX || AW < 2) begin : g_param_check
        $error("decoder_group_fifo: RD_GROUP must be 1..%0d and AW >= 2",
               DECODER_FIFO_RD_GROUP_MAX);
    end

    logic [LW-1:0] wr_ptr_d;
    logic [LW-1:0] wr_ptr_q;
    logic [LW-1:0] rd_ptr_d;
    logic [LW-1:0] rd_ptr_q;
    logic          valid_d;
    logic          valid_q;
    fifo_acc_t     acc;

    // Readiness depends only on registered pointers, never on this cycle's requests.
    assign level    = wr_ptr_q - rd_ptr_q;
    assign wr_ready = (level != DEPTH);
    assign rd_ready = (level >= GROUP);

    always_comb begin
        acc.wr = we && wr_ready && !flush;
        acc.rd = re && rd_ready && !flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = acc.rd;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (acc.wr) begin
                wr_ptr_d = wr_ptr_q + ONE;
            end
            if (acc.rd) begin
                rd_ptr_d = rd_ptr_q + GROUP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    assign valid_out = valid_q;

`ifdef DECODER_FIFO_ERR_FLAGS_EN
    logic ovf_d;
    logic ovf_q;
    logic unf_d;
    logic unf_q;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (flush) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (we && !wr_ready) begin
                ovf_d = 1'b1;
            end
            if (re && !rd_ready) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
`endif

    // A write never targets an address inside the group being read, so no bypass is needed.
    decoder_group_fifo_ram #(
        .AW       (AW),
        .DW       (DW),
        .RD_GROUP (RD_GROUP)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (acc.wr),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (data_in),
        .rd_en   (acc.rd),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (data_out)
    );

endmodule
